pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Central sequencer for the five-stage pipeline. Replaces the single shared `valid` enable with
//   per-stage enable/flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//   Detects load-use hazards, EX-stage redirects, data-memory wait states and ebreak. Runs the
//   RUN/DRAIN/HALTED state machine and keeps saturating stall/flush performance counters.
// PARAMETERS
//   REG_AW        5   register-index width
//   CNT_W         32  performance-counter width
//   DRAIN_CYCLES  3   cycles after ebreak leaves ID until it retires (EX, MEM, WB)
// PORTS
//   sys_clk       in   1        system clock
//   sys_rst       in   1        synchronous reset, active-low
//   id_rs1        in   REG_AW   rs1 index of instruction in ID
//   id_rs1_used   in   1        ID instruction reads rs1
//   id_rs2        in   REG_AW   rs2 index of instruction in ID
//   id_rs2_used   in   1        ID instruction reads rs2
//   id_ebreak     in   1        ID instruction is ebreak
//   ex_rd         in   REG_AW   destination index of instruction in EX
//   ex_is_load    in   1        EX instruction is a load (wb_select == memory)
//   ex_pc_sel     in   1        EX resolved a taken branch/jump; PC takes alu_res
//   mem_busy      in   1        data memory not ready; MEM instruction must hold
//   pc_en         out  1        PC register update enable
//   if_id_en      out  1        IF/ID load enable
//   if_id_flush   out  1        IF/ID loads a bubble (nop, valid=0)
//   id_ex_en      out  1        ID/EX load enable
//   id_ex_flush   out  1        ID/EX loads a bubble
//   ex_mem_en     out  1        EX/MEM load enable
//   mem_wb_en     out  1        MEM/WB load enable
//   mem_wb_flush  out  1        MEM/WB loads a bubble
//   halted        out  1        core halted after ebreak retired
//   stall_cnt     out  CNT_W    load-use bubbles inserted
//   flush_cnt     out  CNT_W    redirects taken
// BEHAVIOUR
//   - State register and counters are updated on the sys_clk rising edge. All control outputs are
//     combinational from state and inputs, with zero added latency.
//   - Reset (sys_rst == 0, sampled on the edge): state=RUN, drain_cnt=0, halted=0, stall_cnt=0,
//     flush_cnt=0. While sys_rst is low, every *_en=0 and every *_flush=1. Reset mid-drain or
//     while halted returns to RUN.
//   - Flush has priority over en in the stage registers: flush=1 loads a bubble even when en=0.
//   - Hazard terms:
//       lu = ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd))
//       x0 never creates a hazard.
//   - RUN state, priority order:
//     1 mem_busy: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1. No counter changes.
//       A pending ex_pc_sel or lu is held and acted on after busy drops.
//     2 ex_pc_sel: pc_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_en=mem_wb_en=1, flush_cnt+=1.
//       lu and id_ebreak are ignored, because the ID instruction is on the wrong path.
//     3 lu: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1, stall_cnt+=1.
//       Exactly one bubble per hazard.
//     4 id_ebreak: ebreak advances into EX (id_ex_en=1). pc_en=0 and if_id_flush=1 stop fetch.
//       Next state DRAIN with drain_cnt=DRAIN_CYCLES-1.
//     5 otherwise: all *_en=1, all flush=0.
//   - DRAIN: pc_en=0, if_id_flush=1, id_ex_flush=1. EX/MEM and MEM/WB stay enabled so older
//     instructions retire. mem_busy freezes the state as in RUN, and drain_cnt does not count.
//     Otherwise drain_cnt-=1. At drain_cnt==0 with !mem_busy, next state is HALTED.
//     ex_pc_sel is not possible in DRAIN because ebreak is the youngest instruction.
//   - HALTED: halted=1, all *_en=0, all flush=0, counters frozen. Only reset leaves HALTED.
//   - Counters saturate at 2^CNT_W-1 and never wrap.
//   - A simultaneous lu and mem_busy counts nothing in that cycle. lu is counted once in the
//     cycle it is actually serviced.
// TESTING
//   T1 load x5; next add x6,x5,x1 -> one cycle pc_en=0/if_id_en=0/id_ex_flush=1, stall_cnt 0->1.
//   T2 load x0; use x0 in ID -> no stall, stall_cnt stays 0. load x5; ID uses only rs2=x5 with
//      rs2_used=0 -> no stall.
//   T3 ex_pc_sel=1 while ID holds a load-use consumer -> if_id_flush=id_ex_flush=1, pc_en=1,
//      flush_cnt=1, stall_cnt=0.
//   T4 mem_busy=1 for 4 cycles with ex_pc_sel=1 -> 4 cycles all en=0, mem_wb_flush=1; the
//      redirect is serviced in cycle 5 and flush_cnt increments once.
//   T5 ebreak in ID with 2 older ALU ops -> pc_en=0 from that cycle; halted=1 exactly 4 cycles
//      later (busy-free). Repeat with 2 busy cycles during DRAIN -> halted 6 cycles later.
//   T6 sys_rst low for 1 cycle during DRAIN/HALTED -> state RUN, halted=0, counters 0;
//      CNT_W=4 preloaded to 15 + lu -> stall_cnt stays 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-stage enable/flush from load-use, redirect, memory-wait and ebreak,
// plus the RUN/DRAIN/HALTED state machine and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_used,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic              id_ebreak,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_pc_sel,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              mem_wb_flush,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          lu;
    logic          stall_inc, flush_inc;

    // x0 is hard-wired zero, so a load targeting it never produces a value to wait for.
    assign lu = ex_is_load && (ex_rd != '0) &&
                ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

    assign state_dbg = state;

    always_comb begin
        state_nxt    = state;
        drain_nxt    = drain_cnt;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        mem_wb_flush = 1'b0;
        halted       = 1'b0;
        if (!sys_rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_busy) begin
                        // Everything upstream of MEM holds; pending redirect/hazard waits.
                        mem_wb_flush = 1'b1;
                    end else if (ex_pc_sel) begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_en    = 1'b1;
                        id_ex_flush = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (lu) begin
                        id_ex_flush = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (id_ebreak) begin
                        if_id_flush = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        state_nxt   = S_DRAIN;
                        drain_nxt   = DRAIN_INIT;
                    end else begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if_id_flush = 1'b1;
                    if (mem_busy) begin
                        // ID/EX may still hold the ebreak itself, so it holds rather than bubbles.
                        mem_wb_flush = 1'b1;
                    end else begin
                        id_ex_flush = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if (drain_cnt == '0) begin
                            state_nxt = S_HALTED;
                        end else begin
                            drain_nxt = drain_cnt - DW'(1);
                        end
                    end
                end
                S_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    state_nxt = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state     <= S_RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl against a stage-action reference model;
// a second instance with 4-bit counters exercises saturation.
module tb_pipe_hazard_ctrl;

    localparam int HOLD = 0;
    localparam int LOAD = 1;
    localparam int BUB  = 2;
    localparam int DC   = 3;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_ebreak = 1'b0;
    logic       ex_is_load = 1'b0, ex_pc_sel = 1'b0, mem_busy = 1'b0;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, mem_wb_en, mem_wb_flush, halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic [1:0]  state_dbg;

    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush;
    logic        s_ex_mem_en, s_mem_wb_en, s_mem_wb_flush, s_halted;
    logic [3:0]  s_stall_cnt, s_flush_cnt;
    logic [1:0]  s_state_dbg;

    int     tests = 0;
    int     fails = 0;
    int     m_mode = M_RUN;
    int     m_left = 0;
    longint m_stall = 0;
    longint m_flush = 0;

    always #5 sys_clk = ~sys_clk;

    pipe_hazard_ctrl dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_ebreak(id_ebreak), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_pc_sel(ex_pc_sel),
        .mem_busy(mem_busy), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_small (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_ebreak(id_ebreak), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_pc_sel(ex_pc_sel),
        .mem_busy(mem_busy), .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
        .id_ex_en(s_id_ex_en), .id_ex_flush(s_id_ex_flush), .ex_mem_en(s_ex_mem_en),
        .mem_wb_en(s_mem_wb_en), .mem_wb_flush(s_mem_wb_flush), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .state_dbg(s_state_dbg)
    );

    function automatic int act(input logic en, input logic flush);
        return flush ? BUB : (en ? LOAD : HOLD);
    endfunction

    // The ID instruction consumes a register that a load in EX has not yet produced.
    function automatic bit load_use();
        bit needs_rs1, needs_rs2;
        needs_rs1 = id_rs1_used && (id_rs1 == ex_rd);
        needs_rs2 = id_rs2_used && (id_rs2 == ex_rd);
        return ex_is_load && (ex_rd != 0) && (needs_rs1 || needs_rs2);
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sys_rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_ebreak = 1'b0;
        ex_is_load = 1'b0; ex_pc_sel = 1'b0; mem_busy = 1'b0;
    endtask

    // Inputs are set just after a falling edge; check, then advance the model on the rising edge.
    task automatic tick();
        int e[5];
        bit e_halt;
        e_halt = 1'b0;
        #1;
        if (!sys_rst)                 e = '{HOLD, BUB, BUB, HOLD, BUB};
        else if (m_mode == M_HALT)    begin e = '{HOLD, HOLD, HOLD, HOLD, HOLD}; e_halt = 1'b1; end
        else if (m_mode == M_DRAIN)   e = mem_busy ? '{HOLD, BUB, DC, HOLD, BUB}
                                                   : '{HOLD, BUB, BUB, LOAD, LOAD};
        else if (mem_busy)            e = '{HOLD, HOLD, HOLD, HOLD, BUB};
        else if (ex_pc_sel)           e = '{LOAD, BUB, BUB, LOAD, LOAD};
        else if (load_use())          e = '{HOLD, HOLD, BUB, LOAD, LOAD};
        else if (id_ebreak)           e = '{HOLD, BUB, LOAD, LOAD, LOAD};
        else                          e = '{LOAD, LOAD, LOAD, LOAD, LOAD};
        check("pc",     act(pc_en, 1'b0), e[0]);
        check("if_id",  act(if_id_en, if_id_flush), e[1]);
        if (e[2] != DC) check("id_ex", act(id_ex_en, id_ex_flush), e[2]);
        check("ex_mem", act(ex_mem_en, 1'b0), e[3]);
        check("mem_wb", act(mem_wb_en, mem_wb_flush), e[4]);
        check("halted", halted, e_halt);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        check("small_stall_cnt", s_stall_cnt, (m_stall > 15) ? 15 : m_stall);
        check("small_flush_cnt", s_flush_cnt, (m_flush > 15) ? 15 : m_flush);
        @(posedge sys_clk);
        if (!sys_rst) begin
            m_mode = M_RUN; m_left = 0; m_stall = 0; m_flush = 0;
        end else if (m_mode == M_RUN) begin
            if (mem_busy)        ;
            else if (ex_pc_sel)  m_flush++;
            else if (load_use()) m_stall++;
            else if (id_ebreak)  begin m_mode = M_DRAIN; m_left = 2; end
        end else if (m_mode == M_DRAIN && !mem_busy) begin
            if (m_left == 0) m_mode = M_HALT;
            else             m_left--;
        end
        @(negedge sys_clk);
    endtask

    initial begin
        // Reset: first edge unchecked (registers start unknown), then a checked reset cycle.
        idle(); sys_rst = 1'b0;
        @(posedge sys_clk); @(negedge sys_clk);
        sys_rst = 1'b0; tick();
        idle(); tick();
        // T1: load x5 in EX, add x6,x5,x1 in ID -> one bubble, then the hazard is gone.
        ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1; id_rs2 = 1; id_rs2_used = 1; tick();
        ex_is_load = 0; ex_rd = 0; tick();
        // T2: load to x0 never stalls; unused rs2 match never stalls.
        ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1; tick();
        ex_rd = 5; id_rs1 = 3; id_rs2 = 5; id_rs2_used = 0; tick();
        // T3: redirect beats a load-use consumer in ID.
        id_rs2_used = 1; ex_pc_sel = 1; tick();
        idle(); tick();
        // T4: four busy cycles hold a redirect; it is taken once in cycle five.
        ex_pc_sel = 1; mem_busy = 1;
        for (int i = 0; i < 4; i++) tick();
        mem_busy = 0; tick();
        idle(); tick();
        // T5: ebreak behind two ALU ops drains to HALTED; then again with busy during drain.
        tick(); tick();
        id_ebreak = 1; tick();
        id_ebreak = 0;
        for (int i = 0; i < 6; i++) tick();
        sys_rst = 0; tick();
        idle(); id_ebreak = 1; tick();
        id_ebreak = 0; tick();
        mem_busy = 1; tick(); tick();
        mem_busy = 0;
        for (int i = 0; i < 5; i++) tick();
        // T6: reset while halted (above) and mid-drain, then saturate the 4-bit counter.
        sys_rst = 0; tick();
        idle(); id_ebreak = 1; tick();
        id_ebreak = 0; tick();
        sys_rst = 0; tick();
        idle(); tick();
        ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1;
        for (int i = 0; i < 18; i++) tick();
        ex_is_load = 0; ex_pc_sel = 1;
        for (int i = 0; i < 18; i++) tick();
        idle(); sys_rst = 0; tick();
        // Random mix of hazards, redirects, waits, ebreaks and occasional resets.
        for (int i = 0; i < 600; i++) begin
            sys_rst     = ($urandom_range(0, 39) != 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1_used = $urandom_range(0, 1) != 0;
            id_rs2_used = $urandom_range(0, 1) != 0;
            ex_is_load  = $urandom_range(0, 1) != 0;
            ex_pc_sel   = $urandom_range(0, 5) == 0;
            mem_busy    = $urandom_range(0, 4) == 0;
            id_ebreak   = $urandom_range(0, 11) == 0;
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
